// File: rtl/aes_decrypt_iterative.sv
// Iterative AES-128 decryption engine. One inverse round per clock. Round keys
// are derived on the fly by walking the key schedule backwards from the round-10 key.
module aes_decrypt_iterative #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inValid,
    output logic         inReady,
    input  logic [127:0] cipherText,
    input  logic [127:0] lastKey,
    output logic         outValid,
    input  logic         outReady,
    output logic [127:0] plainText
);

    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned RND_W   = 4;

    // Only the AES-128 schedule is implemented.
    if (NUM_ROUNDS != 10) begin : g_bad_rounds
        $error("aes_decrypt_iterative: only NUM_ROUNDS = 10 is supported");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_e;

    // Forward S-box, used by the backwards key schedule.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse S-box, used by the round datapath.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns on one column (byte 0 in the MSBs).
    function automatic logic [WORD_W-1:0] inv_mix_col(input logic [WORD_W-1:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // S-box applied to every byte of a word.
    function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Rcon needed to step back from k(11-r) to k(10-r) during round r.
    function automatic logic [7:0] rcon_for_round(input logic [RND_W-1:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h36;
            4'd2:    rc = 8'h1b;
            4'd3:    rc = 8'h80;
            4'd4:    rc = 8'h40;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h10;
            4'd7:    rc = 8'h08;
            4'd8:    rc = 8'h04;
            4'd9:    rc = 8'h02;
            4'd10:   rc = 8'h01;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // One step of the AES-128 key schedule run backwards.
    function automatic logic [BLOCK_W-1:0] prev_round_key(input logic [BLOCK_W-1:0] k,
                                                          input logic [7:0]         rc);
        logic [WORD_W-1:0] w0, w1, w2, w3;
        logic [WORD_W-1:0] p0, p1, p2, p3;
        {w0, w1, w2, w3} = k;
        p3 = w3 ^ w2;
        p2 = w2 ^ w1;
        p1 = w1 ^ w0;
        p0 = w0 ^ sub_word({p3[23:0], p3[31:24]}) ^ {rc, 24'h000000};
        return {p0, p1, p2, p3};
    endfunction

    // InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
    function automatic logic [BLOCK_W-1:0] inv_round(input logic [BLOCK_W-1:0] s,
                                                     input logic [BLOCK_W-1:0] rk,
                                                     input logic               last);
        logic [BLOCK_W-1:0] t;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127-8*(4*c+r) -: 8] = INV_SBOX[s[127-8*(4*((c+4-r)%4)+r) -: 8]];
            end
        end
        t = t ^ rk;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                t[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
            end
        end
        return t;
    endfunction

    fsm_e               fsm_q, fsm_d;
    logic [RND_W-1:0]   round_q, round_d;
    logic [BLOCK_W-1:0] state_q, state_d;
    logic [BLOCK_W-1:0] key_q, key_d;
    logic [BLOCK_W-1:0] plain_q, plain_d;

    logic [BLOCK_W-1:0] prev_key_c;
    logic [BLOCK_W-1:0] round_res_c;
    logic               last_round_c;
    logic               round_ok_c;

    // Shared round datapath: previous round key and the inverse round result.
    assign prev_key_c   = prev_round_key(key_q, rcon_for_round(round_q));
    assign last_round_c = (round_q == RND_W'(NUM_ROUNDS));
    assign round_ok_c   = (round_q >= RND_W'(1)) && (round_q <= RND_W'(NUM_ROUNDS));
    assign round_res_c  = inv_round(state_q, prev_key_c, last_round_c);

    // Handshake flags decode directly from the FSM state.
    assign inReady   = (fsm_q == IDLE);
    assign outValid  = (fsm_q == DONE);
    assign plainText = plain_q;

    // State, key, counter and result registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q   <= IDLE;
            round_q <= '0;
            state_q <= '0;
            key_q   <= '0;
            plain_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
            key_q   <= key_d;
            plain_q <= plain_d;
        end
    end

    // Next-state logic: accept in IDLE, iterate in ROUND, hold result in DONE.
    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        state_d = state_q;
        key_d   = key_q;
        plain_d = plain_q;
        case (fsm_q)
            IDLE: begin
                if (inValid) begin
                    state_d = cipherText ^ lastKey;
                    key_d   = lastKey;
                    round_d = RND_W'(1);
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                if (round_ok_c) begin
                    state_d = round_res_c;
                    key_d   = prev_key_c;
                    round_d = round_q + RND_W'(1);
                    if (last_round_c) begin
                        plain_d = round_res_c;
                        fsm_d   = DONE;
                    end
                end else begin
                    fsm_d = IDLE;
                end
            end
            DONE: begin
                if (outReady) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

endmodule
